// File: rtl/serial_init_port_if.sv
// Core-side and bus-side signals of the initiator serial port.
// master is the port itself; slave is the core/bus/arbiter environment.
interface serial_init_port_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  init_req;
  logic                  arbiter_grant;
  logic [DATA_WIDTH-1:0] init_data_out;
  logic                  init_data_out_valid;
  logic [ADDR_WIDTH-1:0] init_addr_out;
  logic                  init_addr_out_valid;
  logic                  init_rw;
  logic                  init_ready;
  logic                  target_split;
  logic                  target_ack;
  logic                  bus_data_in_valid;
  logic                  bus_data_in;
  logic                  bus_data_out;
  logic                  init_grant;
  logic [DATA_WIDTH-1:0] init_data_in;
  logic                  init_data_in_valid;
  logic                  bus_data_out_valid;
  logic                  arbiter_req;
  logic                  bus_mode;
  logic                  init_ack;
  logic                  bus_init_ready;
  logic                  bus_init_rw;
  logic                  init_split_ack;

  modport master (
    input  init_req, arbiter_grant, init_data_out, init_data_out_valid,
           init_addr_out, init_addr_out_valid, init_rw, init_ready,
           target_split, target_ack, bus_data_in_valid, bus_data_in,
    output bus_data_out, init_grant, init_data_in, init_data_in_valid,
           bus_data_out_valid, arbiter_req, bus_mode, init_ack,
           bus_init_ready, bus_init_rw, init_split_ack
  );

  modport slave (
    output init_req, arbiter_grant, init_data_out, init_data_out_valid,
           init_addr_out, init_addr_out_valid, init_rw, init_ready,
           target_split, target_ack, bus_data_in_valid, bus_data_in,
    input  bus_data_out, init_grant, init_data_in, init_data_in_valid,
           bus_data_out_valid, arbiter_req, bus_mode, init_ack,
           bus_init_ready, bus_init_rw, init_split_ack
  );
endinterface

// File: rtl/serial_init_port.sv
// Initiator bus port: arbitrates, serialises address/write data MSB first,
// and deserialises read data (optionally after a target split).
module serial_init_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_init_port_if.master sif
);
  localparam int CW = $clog2(ADDR_WIDTH + 1);
  localparam int RW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] ALAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DLAST = CW'(DATA_WIDTH - 1);
  localparam logic [RW-1:0] RLAST = RW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, ADDR, DATA, WAIT_ACK, SPLIT_WAIT, RX
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_sr_q, addr_sr_d;
  logic [DATA_WIDTH-1:0] data_sr_q, data_sr_d;
  logic                  rw_q, rw_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [RW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dvld_q, dvld_d;
  logic [DATA_WIDTH-1:0] rx_shift;

  assign rx_shift = {rx_sr_q[DATA_WIDTH-2:0], sif.bus_data_in};

  always_comb begin
    state_d   = state_q;
    addr_sr_d = addr_sr_q;
    data_sr_d = data_sr_q;
    rw_d      = rw_q;
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    rx_cnt_d  = rx_cnt_q;
    dout_d    = dout_q;
    dvld_d    = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (sif.init_req) state_d = REQ;
      end
      REQ: begin
        if (sif.arbiter_grant && sif.init_addr_out_valid) begin
          addr_sr_d = sif.init_addr_out;
          // write data presented without its valid is serialised as zeros
          data_sr_d = sif.init_data_out & {DATA_WIDTH{sif.init_data_out_valid}};
          rw_d      = sif.init_rw;
          bit_cnt_d = '0;
          rx_cnt_d  = '0;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        addr_sr_d = addr_sr_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == ALAST) begin
          bit_cnt_d = '0;
          state_d   = rw_q ? DATA : WAIT_ACK;
        end
      end
      DATA: begin
        data_sr_d = data_sr_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == DLAST) begin
          bit_cnt_d = '0;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (rw_q) begin
          if (sif.target_ack) state_d = IDLE;
        end else if (sif.bus_data_in_valid) begin
          // an early read bit wins over a simultaneous split
          rx_sr_d  = rx_shift;
          rx_cnt_d = RW'(1);
          state_d  = RX;
        end else if (sif.target_split) begin
          state_d = SPLIT_WAIT;
        end else if (sif.target_ack) begin
          state_d = RX;
        end
      end
      SPLIT_WAIT: begin
        if (sif.bus_data_in_valid) begin
          rx_sr_d  = rx_shift;
          rx_cnt_d = RW'(1);
          state_d  = RX;
        end
      end
      RX: begin
        if (sif.bus_data_in_valid) begin
          if (rx_cnt_q == RLAST) begin
            dout_d   = rx_shift;
            dvld_d   = 1'b1;
            rx_cnt_d = '0;
            state_d  = IDLE;
          end else begin
            rx_sr_d  = rx_shift;
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_sr_q <= '0;
      data_sr_q <= '0;
      rw_q      <= 1'b0;
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      rx_cnt_q  <= '0;
      dout_q    <= '0;
      dvld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_sr_q <= addr_sr_d;
      data_sr_q <= data_sr_d;
      rw_q      <= rw_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sr_q   <= rx_sr_d;
      rx_cnt_q  <= rx_cnt_d;
      dout_q    <= dout_d;
      dvld_q    <= dvld_d;
    end
  end

  // serial outputs decode from registered state so reset clears them at once
  assign sif.bus_data_out       = (state_q == ADDR) ? addr_sr_q[ADDR_WIDTH-1] :
                                  (state_q == DATA) ? data_sr_q[DATA_WIDTH-1] : 1'b0;
  assign sif.bus_data_out_valid = (state_q == ADDR) || (state_q == DATA);
  assign sif.bus_mode           = (state_q == ADDR);
  assign sif.arbiter_req        = ((state_q == IDLE) && sif.init_req) ||
                                  (state_q == REQ) || (state_q == ADDR) ||
                                  (state_q == DATA) || (state_q == WAIT_ACK);
  assign sif.bus_init_rw        = rw_q;
  assign sif.init_data_in       = dout_q;
  assign sif.init_data_in_valid = dvld_q;
  assign sif.init_grant         = sif.arbiter_grant;
  assign sif.init_ack           = sif.target_ack;
  assign sif.init_split_ack     = sif.target_split;
  assign sif.bus_init_ready     = sif.init_ready;
endmodule

// File: tb/tb_serial_init_port.sv
// Directed bench for serial_init_port: write, split read, gapped read,
// delayed grant and mid-address reset.
module tb_serial_init_port;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  serial_init_port_if sif ();
  serial_init_port dut (.clk(clk), .rst_n(rst_n), .sif(sif));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the 16 address beats starting in the current ADDR cycle.
  task automatic addr_beats(input logic [15:0] a);
    for (int i = 15; i >= 0; i--) begin
      chk($sformatf("addr_bit%0d", i), {29'd0, sif.bus_data_out, sif.bus_data_out_valid, sif.bus_mode},
          {29'd0, a[i], 1'b1, 1'b1});
      tick();
    end
  endtask

  task automatic data_beats(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      chk($sformatf("data_bit%0d", i), {29'd0, sif.bus_data_out, sif.bus_data_out_valid, sif.bus_mode},
          {29'd0, d[i], 1'b1, 1'b0});
      tick();
    end
  endtask

  task automatic start_txn(input logic [15:0] a, input logic [7:0] d, input logic rw);
    sif.init_req = 1'b1; sif.arbiter_grant = 1'b1;
    sif.init_addr_out = a; sif.init_addr_out_valid = 1'b1;
    sif.init_data_out = d; sif.init_data_out_valid = 1'b1; sif.init_rw = rw;
    tick();  // IDLE -> REQ
    tick();  // REQ -> ADDR
    // core inputs change after latching; the port must ignore them
    sif.init_req = 1'b0; sif.init_addr_out = 16'hFFFF; sif.init_data_out = 8'h00;
    sif.init_rw = ~rw; sif.init_addr_out_valid = 1'b0; sif.arbiter_grant = 1'b0;
  endtask

  initial begin
    sif.init_req = 0; sif.arbiter_grant = 0; sif.init_data_out = 0;
    sif.init_data_out_valid = 0; sif.init_addr_out = 0; sif.init_addr_out_valid = 0;
    sif.init_rw = 0; sif.init_ready = 0; sif.target_split = 0; sif.target_ack = 0;
    sif.bus_data_in_valid = 0; sif.bus_data_in = 0;
    #1;
    chk("rst_outs", {sif.bus_data_out, sif.bus_data_out_valid, sif.bus_mode, sif.arbiter_req,
                     sif.init_data_in_valid, sif.bus_init_rw, 2'b0}, 8'h00);
    chk("rst_data_in", sif.init_data_in, 0);
    #20 rst_n = 1'b1;
    tick();

    // pass-throughs
    sif.arbiter_grant = 1; sif.target_ack = 1; sif.target_split = 1; sif.init_ready = 1;
    #1;
    chk("pass_hi", {sif.init_grant, sif.init_ack, sif.init_split_ack, sif.bus_init_ready}, 4'hF);
    sif.arbiter_grant = 0; sif.target_ack = 0; sif.target_split = 0; sif.init_ready = 0;
    #1;
    chk("pass_lo", {sif.init_grant, sif.init_ack, sif.init_split_ack, sif.bus_init_ready}, 4'h0);
    tick();

    // write 0x5C to 0x800A
    sif.init_req = 1; #1;
    chk("wr_req_idle", sif.arbiter_req, 1);
    start_txn(16'h800A, 8'h5C, 1'b1);
    chk("wr_rw", sif.bus_init_rw, 1);
    addr_beats(16'h800A);
    data_beats(8'h5C);
    chk("wr_wait_idle_bus", {sif.bus_data_out_valid, sif.bus_mode, sif.arbiter_req}, 3'b001);
    tick();
    chk("wr_wait_hold", sif.arbiter_req, 1);
    sif.target_ack = 1; tick(); sif.target_ack = 0;
    chk("wr_done_req", sif.arbiter_req, 0);
    chk("wr_no_rdvld", sif.init_data_in_valid, 0);
    chk("wr_rw_hold", sif.bus_init_rw, 1);
    tick();

    // split read at 0x800A returning 0x5C
    start_txn(16'h800A, 8'h00, 1'b0);
    chk("rd_rw", sif.bus_init_rw, 0);
    addr_beats(16'h800A);
    chk("rd_wait_req", {sif.arbiter_req, sif.bus_data_out_valid}, 2'b10);
    sif.target_split = 1; #1;
    chk("split_ack", sif.init_split_ack, 1);
    tick(); sif.target_split = 0; #1;
    chk("split_req_drop", {sif.arbiter_req, sif.init_split_ack}, 2'b00);
    tick(); tick();
    chk("split_still_wait", sif.arbiter_req, 0);
    for (int i = 7; i >= 0; i--) begin
      chk($sformatf("split_novld%0d", i), sif.init_data_in_valid, 0);
      sif.bus_data_in_valid = 1; sif.bus_data_in = 1'((8'h5C >> i) & 8'h01);
      tick();
    end
    sif.bus_data_in_valid = 0; sif.bus_data_in = 0;
    chk("split_vld", sif.init_data_in_valid, 1);
    chk("split_data", sif.init_data_in, 8'h5C);
    tick();
    chk("split_vld_once", sif.init_data_in_valid, 0);
    chk("split_data_hold", sif.init_data_in, 8'h5C);

    // non-split read, ack then bits 0xA5 with 2-cycle gaps
    start_txn(16'h0F31, 8'h00, 1'b0);
    addr_beats(16'h0F31);
    sif.target_ack = 1; tick(); sif.target_ack = 0;
    for (int i = 7; i >= 0; i--) begin
      sif.bus_data_in_valid = 1; sif.bus_data_in = 1'((8'hA5 >> i) & 8'h01);
      tick();
      sif.bus_data_in_valid = 0; sif.bus_data_in = ~sif.bus_data_in;
      if (i != 0) begin
        chk($sformatf("gap_novld%0d", i), sif.init_data_in_valid, 0);
        tick(); tick();
      end
    end
    chk("gap_vld", sif.init_data_in_valid, 1);
    chk("gap_data", sif.init_data_in, 8'hA5);
    tick();
    chk("gap_vld_once", sif.init_data_in_valid, 0);
    chk("gap_data_hold", sif.init_data_in, 8'hA5);

    // delayed grant: request held 10 cycles with no grant
    sif.init_req = 1; sif.init_addr_out = 16'hC001; sif.init_addr_out_valid = 1;
    sif.init_rw = 1; sif.init_data_out = 8'h3C; sif.init_data_out_valid = 1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("nogrant%0d", i), {sif.arbiter_req, sif.bus_data_out_valid}, 2'b10);
      tick();
    end
    sif.arbiter_grant = 1; #1;
    chk("grant_fwd", sif.init_grant, 1);
    chk("grant_same_cycle", sif.bus_data_out_valid, 0);
    tick(); sif.init_req = 0; sif.arbiter_grant = 0;
    chk("grant_start", {sif.bus_data_out, sif.bus_data_out_valid, sif.bus_mode}, 3'b111);
    tick(); tick(); tick();
    chk("mid_addr", {sif.bus_data_out_valid, sif.bus_mode}, 2'b11);

    // async reset mid-ADDR
    #2 rst_n = 1'b0; #1;
    chk("arst_outs", {sif.bus_data_out, sif.bus_data_out_valid, sif.bus_mode, sif.arbiter_req,
                      sif.init_data_in_valid, sif.bus_init_rw}, 6'b0);
    chk("arst_data_in", sif.init_data_in, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // fresh write after reset
    start_txn(16'h00FF, 8'h81, 1'b1);
    addr_beats(16'h00FF);
    data_beats(8'h81);
    sif.target_ack = 1; tick(); sif.target_ack = 0;
    chk("post_rst_idle", {sif.arbiter_req, sif.bus_data_out_valid, sif.init_data_in_valid}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
